testbasic5_feeder: RTL and testbench

Buffered upstream stage for the TestBasic5 block: accepts 32-bit integers from a producer over a blocking sync/notify port and presents them, in order, on a blocking output port wired directly to TestBasic5's `b_in` port. It decouples producer bursts from TestBasic5's consumption with a DEPTH-entry circular buffer. All transfers use the codebase handshake: a word moves on a rising `clk` edge when both `*_notify` and `*_sync` of that port are high.

---
 rtl/testbasic5_feeder_pkg.sv | 20 ++
 rtl/testbasic5_feeder_ram.sv | 33 +++
 rtl/testbasic5_feeder.sv | 108 ++++++++++
 tb/tb_testbasic5_feeder.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/testbasic5_feeder_pkg.sv
// ============================================================================
// Module   : testbasic5_feeder_types
// Purpose  : Shared section encoding and data width for the TestBasic5 feeder
// Revision : 1.0
// ============================================================================
`default_nettype none

package testbasic5_feeder_types;

   localparam int FEEDER_DATA_W = 32;

   typedef enum logic [1:0] {
      empty = 2'd0,
      busy  = 2'd1,
      full  = 2'd2
   } TestBasic5_Feeder_SECTIONS;

endpackage

`default_nettype wire

// File: rtl/testbasic5_feeder_ram.sv
// ============================================================================
// Module   : testbasic5_feeder_ram
// Purpose  : DEPTH x 32 storage, synchronous write, asynchronous read, no reset
// Revision : 1.0
// ============================================================================
`default_nettype none

module testbasic5_feeder_ram
   import testbasic5_feeder_types::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                              clk,
   input  logic                              we,
   input  logic [$clog2(DEPTH)-1:0]          waddr,
   input  logic signed [FEEDER_DATA_W-1:0]   wdata,
   input  logic [$clog2(DEPTH)-1:0]          raddr,
   output logic signed [FEEDER_DATA_W-1:0]   rdata
);

   logic signed [FEEDER_DATA_W-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         r_mem[waddr] <= wdata;
      end
   end

   assign rdata = r_mem[raddr];

endmodule

`default_nettype wire

// File: rtl/testbasic5_feeder.sv
// ============================================================================
// Module   : testbasic5_feeder
// Purpose  : DEPTH-entry circular buffer feeding TestBasic5 b_in.
//            Optional zero-cycle empty bypass: TESTBASIC5_FEEDER_BYPASS_EN
// Revision : 1.0
// ============================================================================
`default_nettype none

module testbasic5_feeder
   import testbasic5_feeder_types::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic signed [FEEDER_DATA_W-1:0]   in,
   input  logic                              in_sync,
   output logic                              in_notify,
   output logic signed [FEEDER_DATA_W-1:0]   out,
   input  logic                              out_sync,
   output logic                              out_notify,
   output logic [$clog2(DEPTH):0]            level
);

   localparam int c_ADDR_W  = $clog2(DEPTH);
   localparam int c_LEVEL_W = c_ADDR_W + 1;

   TestBasic5_Feeder_SECTIONS         r_section;
   logic [c_ADDR_W-1:0]               r_wr_ptr;
   logic [c_ADDR_W-1:0]               r_rd_ptr;
   logic [c_LEVEL_W-1:0]              r_level;
   logic signed [FEEDER_DATA_W-1:0]   r_last;

   logic                              w_push;
   logic                              w_pop;
   logic                              w_bypass;
   logic [c_LEVEL_W-1:0]              w_level_nxt;
   logic signed [FEEDER_DATA_W-1:0]   w_rd_data;

   testbasic5_feeder_ram #(
      .DEPTH (DEPTH)
   ) u_ram (
      .clk   (clk),
      .we    (w_push),
      .waddr (r_wr_ptr),
      .wdata (in),
      .raddr (r_rd_ptr),
      .rdata (w_rd_data)
   );

   assign in_notify = (r_section != full);

`ifdef TESTBASIC5_FEEDER_BYPASS_EN
   // Empty buffer with both sides ready: hand the word straight across
   assign w_bypass   = (r_section == empty) && in_sync && out_sync;
   assign out_notify = (r_section != empty) || w_bypass;
   assign out        = w_bypass ? in : ((r_section == empty) ? r_last : w_rd_data);
`else
   assign w_bypass   = 1'b0;
   assign out_notify = (r_section != empty);
   assign out        = (r_section == empty) ? r_last : w_rd_data;
`endif

   assign w_push = in_sync && in_notify && !w_bypass;
   assign w_pop  = out_sync && (r_section != empty);

   always_comb begin
      w_level_nxt = r_level;
      if (w_push && !w_pop) begin
         w_level_nxt = r_level + c_LEVEL_W'(1);
      end else if (w_pop && !w_push) begin
         w_level_nxt = r_level - c_LEVEL_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_section <= empty;
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_level   <= '0;
         r_last    <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + c_ADDR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_ADDR_W'(1);
            r_last   <= w_rd_data;
         end else if (w_bypass) begin
            r_last   <= in;
         end
         r_level <= w_level_nxt;
         if (w_level_nxt == '0) begin
            r_section <= empty;
         end else if (w_level_nxt == c_LEVEL_W'(DEPTH)) begin
            r_section <= full;
         end else begin
            r_section <= busy;
         end
      end
   end

   assign level = r_level;

endmodule

`default_nettype wire

// File: tb/tb_testbasic5_feeder.sv
// ============================================================================
// Module   : tb_testbasic5_feeder
// Purpose  : Self-checking bench for testbasic5_feeder against a queue model
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_testbasic5_feeder;

   localparam int DEPTH = 4;
   localparam int LW    = $clog2(DEPTH) + 1;
   localparam int OW    = 2 + LW + 32;

   logic               clk;
   logic               rst;
   logic signed [31:0] din;
   logic               in_sync;
   logic               in_notify;
   logic signed [31:0] dout;
   logic               out_sync;
   logic               out_notify;
   logic [LW-1:0]      level;

   int checks;
   int errors;

   // Reference model: in-order queue plus the last value handed out
   int          q[$];
   logic [31:0] last;

   testbasic5_feeder #(
      .DEPTH (DEPTH)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in         (din),
      .in_sync    (in_sync),
      .in_notify  (in_notify),
      .out        (dout),
      .out_sync   (out_sync),
      .out_notify (out_notify),
      .level      (level)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic model_bypass(logic is, logic os);
      logic b;
      b = 1'b0;
`ifdef TESTBASIC5_FEEDER_BYPASS_EN
      b = (q.size() == 0) && is && os;
`endif
      return b;
   endfunction

   function automatic logic [OW-1:0] model_obs(logic is, logic os, logic [31:0] d);
      logic        byp;
      logic [31:0] o;
      byp = model_bypass(is, os);
      o   = byp ? d : ((q.size() != 0) ? 32'(q[0]) : last);
      return {q.size() != DEPTH, (q.size() != 0) || byp, LW'(q.size()), o};
   endfunction

   function automatic void model_reset();
      q.delete();
      last = '0;
   endfunction

   task automatic drive(input logic is, input logic os, input logic [31:0] d);
      @(negedge clk);
      in_sync  = is;
      out_sync = os;
      din      = d;
      #1;
   endtask

   task automatic tick(input logic is, input logic os, input logic [31:0] d);
      logic full_before;
      full_before = (q.size() == DEPTH);
      if (model_bypass(is, os)) begin
         last = d;
      end else begin
         if (os && q.size() != 0) last = 32'(q.pop_front());
         if (is && !full_before) q.push_back(int'(d));
      end
      @(posedge clk);
   endtask

   task automatic test_reset();
      logic [OW-1:0] exp_v;
      rst = 1'b1; in_sync = 0; out_sync = 0; din = 0;
      #2 rst = 1'b0;
      #1;
      model_reset();
      exp_v = {1'b1, 1'b0, LW'(0), 32'd0};
      checks++;
      if ({in_notify, out_notify, level, dout} !== exp_v) begin
         errors++;
         $display("FAIL reset_asserted: got %h expected %h", {in_notify, out_notify, level, dout}, exp_v);
      end
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 0);
         checks++;
         if ({in_notify, out_notify, level, dout} !== exp_v) begin
            errors++;
            $display("FAIL reset_idle[%0d]: got %h expected %h", i, {in_notify, out_notify, level, dout}, exp_v);
         end
         tick(0, 0, 0);
      end
   endtask

   task automatic test_fill();
      int vals[6] = '{10, 20, 30, 40, 50, 50};
      logic [OW-1:0] exp_v;
      for (int i = 0; i < 6; i++) begin
         drive(1, 0, 32'(vals[i]));
         exp_v = model_obs(1, 0, 32'(vals[i]));
         checks++;
         if ({in_notify, out_notify, level, dout} !== exp_v) begin
            errors++;
            $display("FAIL fill[%0d]: got %h expected %h", i, {in_notify, out_notify, level, dout}, exp_v);
         end
         tick(1, 0, 32'(vals[i]));
      end
   endtask

   task automatic test_drain(input int n);
      logic [OW-1:0] exp_v;
      for (int i = 0; i < n; i++) begin
         drive(0, 1, 32'hDEAD_0000 + 32'(i));
         exp_v = model_obs(0, 1, 32'hDEAD_0000 + 32'(i));
         checks++;
         if ({in_notify, out_notify, level, dout} !== exp_v) begin
            errors++;
            $display("FAIL drain[%0d]: got %h expected %h", i, {in_notify, out_notify, level, dout}, exp_v);
         end
         tick(0, 1, 32'hDEAD_0000 + 32'(i));
      end
   endtask

   task automatic test_full_concurrent();
      logic [OW-1:0] exp_v;
      logic          is_t [6] = '{1, 1, 1, 1, 1, 1};
      logic          os_t [6] = '{0, 0, 0, 0, 1, 0};
      int            d_t  [6] = '{1, 2, 3, 4, 99, 99};
      for (int i = 0; i < 6; i++) begin
         drive(is_t[i], os_t[i], 32'(d_t[i]));
         exp_v = model_obs(is_t[i], os_t[i], 32'(d_t[i]));
         checks++;
         if ({in_notify, out_notify, level, dout} !== exp_v) begin
            errors++;
            $display("FAIL full_concurrent[%0d]: got %h expected %h", i, {in_notify, out_notify, level, dout}, exp_v);
         end
         tick(is_t[i], os_t[i], 32'(d_t[i]));
      end
      test_drain(5);
   endtask

   task automatic test_streaming();
      logic [OW-1:0] exp_v;
      for (int i = 0; i < 20; i++) begin
         drive(1, 1, 32'(i));
         exp_v = model_obs(1, 1, 32'(i));
         checks++;
         if ({in_notify, out_notify, level, dout} !== exp_v) begin
            errors++;
            $display("FAIL streaming[%0d]: got %h expected %h", i, {in_notify, out_notify, level, dout}, exp_v);
         end
         tick(1, 1, 32'(i));
      end
      test_drain(2);
   endtask

   task automatic test_random();
      logic [OW-1:0] exp_v;
      logic          is, os;
      logic [31:0]   d;
      for (int i = 0; i < 300; i++) begin
         is = ($urandom_range(0, 99) < 60);
         os = ($urandom_range(0, 99) < 45);
         d  = $urandom;
         drive(is, os, d);
         exp_v = model_obs(is, os, d);
         checks++;
         if ({in_notify, out_notify, level, dout} !== exp_v) begin
            errors++;
            $display("FAIL random[%0d]: got %h expected %h", i, {in_notify, out_notify, level, dout}, exp_v);
         end
         tick(is, os, d);
      end
      test_drain(DEPTH + 1);
   endtask

   task automatic test_reset_mid();
      logic [OW-1:0] exp_v;
      for (int i = 0; i < 3; i++) begin
         drive(1, 0, 32'(100 + i));
         tick(1, 0, 32'(100 + i));
      end
      @(negedge clk);
      in_sync = 0; out_sync = 0;
      rst = 1'b0;
      #1;
      model_reset();
      exp_v = {1'b1, 1'b0, LW'(0), 32'd0};
      checks++;
      if ({in_notify, out_notify, level, dout} !== exp_v) begin
         errors++;
         $display("FAIL reset_mid: got %h expected %h", {in_notify, out_notify, level, dout}, exp_v);
      end
      #1 rst = 1'b1;
      drive(1, 0, 32'd7);
      tick(1, 0, 32'd7);
      drive(0, 0, 32'd0);
      exp_v = {1'b1, 1'b1, LW'(1), 32'd7};
      checks++;
      if ({in_notify, out_notify, level, dout} !== exp_v) begin
         errors++;
         $display("FAIL reset_mid_push7: got %h expected %h", {in_notify, out_notify, level, dout}, exp_v);
      end
      tick(0, 0, 32'd0);
      test_drain(2);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      last   = '0;
      test_reset();
      test_fill();
      test_drain(6);
      test_full_concurrent();
      test_streaming();
      test_random();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
